ts_packet_scheduler: RTL and testbench

//  Packet-granular round-robin scheduler for the 4 MPEG-2 TS input channels.

---
 rtl/ts_packet_scheduler_if.sv | 24 ++
 rtl/ts_packet_scheduler.sv | 92 +++++++++
 tb/tb_ts_packet_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_packet_scheduler_if.sv
// Handshake bundle between the TS packet scheduler, the per-channel input FIFOs,
// the byte mux and the output FIFO.
interface ts_packet_scheduler_if;
   logic [3:0] pkt_rdy;
   logic [7:0] mux_data;
   logic       fifo_full;
   logic [1:0] mux_ctrl;
   logic [3:0] rd_en;
   logic       fifo_wr;
   logic       pkt_done;
   logic       sync_err;

   // Scheduler side.
   modport master (
      input  pkt_rdy, mux_data, fifo_full,
      output mux_ctrl, rd_en, fifo_wr, pkt_done, sync_err
   );

   // Channel / mux / output FIFO side.
   modport slave (
      output pkt_rdy, mux_data, fifo_full,
      input  mux_ctrl, rd_en, fifo_wr, pkt_done, sync_err
   );
endinterface

// File: rtl/ts_packet_scheduler.sv
// Packet-granular round-robin scheduler for four MPEG-2 TS channels: grants one
// channel per 188-byte packet, strobes its bytes into the output FIFO, checks sync.
module ts_packet_scheduler #(
   parameter int unsigned PKT_LEN   = 188,
   parameter logic [7:0]  SYNC_BYTE = 8'h47,
   parameter int unsigned CNT_W     = 8
) (
   input logic                   clk,
   input logic                   rst,
   ts_packet_scheduler_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      XFER  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       last_grant;
   logic [1:0]       grant_nxt;
   logic [1:0]       cand;
   logic             grant_vld;
   logic [CNT_W-1:0] byte_cnt;
   logic             wr;
   logic             last_byte;

   assign last_byte = (byte_cnt == LAST_CNT);

   // Round-robin pick: scan offsets 4..1 so the nearest ready channel after
   // last_grant is the final (winning) assignment; 2-bit add wraps mod 4.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      grant_vld = 1'b0;
      grant_nxt = last_grant;
      cand      = last_grant;
      for (int i = 4; i >= 1; i--) begin
         cand = last_grant + 2'(i);
         if (bus.pkt_rdy[cand]) begin
            grant_vld = 1'b1;
            grant_nxt = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|bus.pkt_rdy) state_nxt = GRANT;
         GRANT:   state_nxt = grant_vld ? XFER : IDLE;
         XFER:    if (wr && last_byte) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr           = (state == XFER) && !bus.fifo_full;
      bus.rd_en    = '0;
      if (wr) bus.rd_en[bus.mux_ctrl] = 1'b1;
      bus.fifo_wr  = wr;
      bus.pkt_done = wr && last_byte;
   end

   // mux_ctrl only changes in GRANT, so it is stable for the whole transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mux_ctrl <= 2'd0;
         last_grant   <= 2'd3;
         byte_cnt     <= '0;
         bus.sync_err <= 1'b0;
      end else begin
         bus.sync_err <= wr && (byte_cnt == '0) && (bus.mux_data != SYNC_BYTE);
         if (state == GRANT && grant_vld) begin
            bus.mux_ctrl <= grant_nxt;
            last_grant   <= grant_nxt;
            byte_cnt     <= '0;
         end else if (wr) begin
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ts_packet_scheduler.sv
// Scoreboard bench for ts_packet_scheduler: stimulus queues expected writes,
// a negedge monitor pops and compares each write the DUT presents.
module tb_ts_packet_scheduler;

   localparam int PKT_LEN = 188;

   typedef struct {
      int ch;
      bit last;
      bit bad;
      int gap;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ts_packet_scheduler_if bus();

   ts_packet_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   wr_cnt      = 0;
   int   done_cnt    = 0;
   int   sync_cnt    = 0;
   int   cyc         = 0;
   int   last_wr     = -100;
   bit   sync_pend   = 1'b0;

   int   src_ptr [4] = '{0, 0, 0, 0};
   int   pkt_num [4] = '{0, 0, 0, 0};
   int   bad_idx [4];
   logic [1:0] sel;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Channel sources: FWFT FIFOs holding back-to-back packets; byte 0 is the sync byte
   // unless that packet number is marked bad.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 4; c++) src_ptr[c] <= 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (bus.rd_en[c]) begin
               if (src_ptr[c] == PKT_LEN - 1) begin
                  src_ptr[c] <= 0;
                  pkt_num[c] <= pkt_num[c] + 1;
               end else begin
                  src_ptr[c] <= src_ptr[c] + 1;
               end
            end
         end
      end
   end

   always_comb begin
      sel = bus.mux_ctrl;
      if (src_ptr[sel] == 0) bus.mux_data = (pkt_num[sel] == bad_idx[sel]) ? 8'h00 : 8'h47;
      else                   bus.mux_data = 8'(int'(sel) * 16 + src_ptr[sel]);
   end

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         sync_pend = 1'b0;
         last_wr   = -100;
      end else begin
         if (bus.sync_err) sync_cnt++;
         if (sync_pend || bus.sync_err) check("sync_err", 32'(bus.sync_err), 32'(sync_pend));
         sync_pend = 1'b0;
         if (bus.pkt_done) check("pkt_done_with_wr", 32'(bus.fifo_wr), 32'd1);
         if (bus.fifo_full) check("rd_en_while_full", 32'(bus.rd_en), 32'd0);
         if (bus.fifo_wr || bus.rd_en != 4'd0) begin
            wr_cnt++;
            if (bus.pkt_done) done_cnt++;
            check("fifo_wr_eq_or_rd_en", 32'(bus.fifo_wr), 32'(|bus.rd_en));
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: rd_en=0x%0h with no write expected (t=%0t)", bus.rd_en, $time);
            end else begin
               e = exp_q.pop_front();
               check("rd_en", 32'(bus.rd_en), 32'(4'b0001 << e.ch));
               check("mux_ctrl", 32'(bus.mux_ctrl), 32'(e.ch));
               check("pkt_done", 32'(bus.pkt_done), 32'(e.last));
               if (e.gap >= 0) check("write_gap", 32'(cyc - last_wr), 32'(e.gap));
               sync_pend = e.bad;
            end
            last_wr = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pkt(input int ch, input int nbytes, input bit bad, input int first_gap,
                           input int in_gap);
      exp_t e;
      for (int i = 0; i < nbytes; i++) begin
         e.ch   = ch;
         e.last = (i == PKT_LEN - 1);
         e.bad  = bad && (i == 0);
         e.gap  = (i == 0) ? first_gap : in_gap;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_q(input int n, input string name);
      int budget;
      budget = 3000;
      while (exp_q.size() > n && budget > 0) begin
         tick();
         budget--;
      end
      if (exp_q.size() > n) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: timeout with %0d writes outstanding, expected at most %0d", name,
                  exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.pkt_rdy   = 4'b0000;
      bus.fifo_full = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int w0, d0, s0;
      for (int c = 0; c < 4; c++) bad_idx[c] = -1;
      bus.pkt_rdy   = 4'b0000;
      bus.fifo_full = 1'b0;

      // 1: reset state, single channel, latency, one pkt_done
      do_reset();
      check("rst_mux_ctrl", 32'(bus.mux_ctrl), 32'd0);
      check("rst_rd_en", 32'(bus.rd_en), 32'd0);
      check("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
      check("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
      check("rst_sync_err", 32'(bus.sync_err), 32'd0);
      w0 = wr_cnt; d0 = done_cnt; s0 = sync_cnt;
      push_pkt(0, PKT_LEN, 1'b0, -1, 1);
      bus.pkt_rdy = 4'b0001;
      check("t1_idle_rd_en", 32'(bus.rd_en), 32'd0);
      tick();
      check("t1_grant_rd_en", 32'(bus.rd_en), 32'd0);
      tick();
      check("t1_first_rd_en", 32'(bus.rd_en), 32'b0001);
      wait_q(100, "t1_mid");
      bus.pkt_rdy = 4'b0000;
      wait_q(0, "t1_end");
      repeat (4) tick();
      check("t1_writes", 32'(wr_cnt - w0), 32'd188);
      check("t1_pkt_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("t1_sync_pulses", 32'(sync_cnt - s0), 32'd0);

      // 2: all channels ready, order 0,1,2,3 with 2 idle cycles between packets
      do_reset();
      w0 = wr_cnt; d0 = done_cnt;
      push_pkt(0, PKT_LEN, 1'b0, -1, 1);
      push_pkt(1, PKT_LEN, 1'b0, 3, 1);
      push_pkt(2, PKT_LEN, 1'b0, 3, 1);
      push_pkt(3, PKT_LEN, 1'b0, 3, 1);
      bus.pkt_rdy = 4'b1111;
      wait_q(100, "t2_mid");
      bus.pkt_rdy = 4'b0000;
      wait_q(0, "t2_end");
      repeat (4) tick();
      check("t2_writes", 32'(wr_cnt - w0), 32'd752);
      check("t2_pkt_done_pulses", 32'(done_cnt - d0), 32'd4);

      // 3: fifo_full 1 on / 2 off; phase puts a stall on the last byte
      do_reset();
      w0 = wr_cnt; d0 = done_cnt;
      push_pkt(0, PKT_LEN, 1'b0, -1, -1);
      bus.pkt_rdy = 4'b0001;
      tick();
      tick();
      for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
         bus.fifo_full = (k % 3 == 1);
         if (k == 5) bus.pkt_rdy = 4'b0000;
         tick();
      end
      bus.fifo_full = 1'b0;
      wait_q(0, "t3_end");
      repeat (4) tick();
      check("t3_writes", 32'(wr_cnt - w0), 32'd188);
      check("t3_pkt_done_pulses", 32'(done_cnt - d0), 32'd1);

      // 4: bad sync byte on ch2, then a good packet on ch2
      do_reset();
      w0 = wr_cnt; s0 = sync_cnt;
      bad_idx[2] = pkt_num[2];
      push_pkt(2, PKT_LEN, 1'b1, -1, 1);
      push_pkt(2, PKT_LEN, 1'b0, 3, 1);
      bus.pkt_rdy = 4'b0100;
      wait_q(100, "t4_mid");
      bus.pkt_rdy = 4'b0000;
      wait_q(0, "t4_end");
      repeat (4) tick();
      check("t4_writes", 32'(wr_cnt - w0), 32'd376);
      check("t4_sync_pulses", 32'(sync_cnt - s0), 32'd1);

      // 5: reset at byte 100 of ch1, then a full ch1 packet from byte 0
      do_reset();
      w0 = wr_cnt;
      push_pkt(1, 100, 1'b0, -1, 1);
      bus.pkt_rdy = 4'b0010;
      wait_q(0, "t5_partial");
      check("t5_pre_rst_rd_en", 32'(bus.rd_en), 32'b0010);
      rst = 1'b1;
      #1;
      check("t5_rst_rd_en", 32'(bus.rd_en), 32'd0);
      check("t5_rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
      check("t5_rst_mux_ctrl", 32'(bus.mux_ctrl), 32'd0);
      check("t5_partial_writes", 32'(wr_cnt - w0), 32'd100);
      tick();
      tick();
      rst = 1'b0;
      w0 = wr_cnt; d0 = done_cnt; s0 = sync_cnt;
      push_pkt(1, PKT_LEN, 1'b0, -1, 1);
      wait_q(100, "t5_mid");
      bus.pkt_rdy = 4'b0000;
      wait_q(0, "t5_end");
      repeat (4) tick();
      check("t5_writes", 32'(wr_cnt - w0), 32'd188);
      check("t5_pkt_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("t5_sync_pulses", 32'(sync_cnt - s0), 32'd0);

      // 6: drop pkt_rdy[1] at byte 50, packet still completes; then 1010 grants ch3
      w0 = wr_cnt;
      push_pkt(1, PKT_LEN, 1'b0, -1, 1);
      bus.pkt_rdy = 4'b0010;
      wait_q(PKT_LEN - 50, "t6_byte50");
      bus.pkt_rdy = 4'b0000;
      wait_q(0, "t6_ch1_end");
      push_pkt(3, PKT_LEN, 1'b0, -1, 1);
      bus.pkt_rdy = 4'b1010;
      wait_q(100, "t6_ch3_mid");
      bus.pkt_rdy = 4'b0000;
      wait_q(0, "t6_ch3_end");
      repeat (4) tick();
      check("t6_writes", 32'(wr_cnt - w0), 32'd376);

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
